// File: rtl/axis_wrr_packet_arbiter_pkg.sv
// Shared definitions for the weighted round-robin packet arbiter.
//  arb_state_t : two-state arbitration FSM encoding (IDLE / XFER)
//  sel_bits()  : width of a source index; never narrower than one bit
//  onehot()    : index -> one-hot vector, all-zero for out-of-range indices
package axis_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    XFER = ST_XFER
  } arb_state_t;

  localparam int MAX_SLAVES = 64;

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_SLAVES-1:0] onehot(input int idx, input int n);
    logic [MAX_SLAVES-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < MAX_SLAVES) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/axis_wrr_packet_arbiter_if.sv
// Bundle of the NSLAVES packed source streams and the single master stream.
//  master : arbiter view (consumes sources, drives the shared master stream)
//  slave  : environment view (drives sources and m_ready)
interface axis_wrr_packet_arbiter_if #(
  parameter int NSLAVES    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
) ();

  logic [NSLAVES-1:0]            s_valid;
  logic [NSLAVES-1:0]            s_ready;
  logic [NSLAVES*DATA_WIDTH-1:0] s_data;
  logic [NSLAVES*DEST_WIDTH-1:0] s_dest;
  logic [NSLAVES*ID_WIDTH-1:0]   s_id;
  logic [NSLAVES-1:0]            s_last;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [DEST_WIDTH-1:0] m_dest;
  logic [ID_WIDTH-1:0]   m_id;
  logic                  m_last;

  modport master (
    input  s_valid, s_data, s_dest, s_id, s_last, m_ready,
    output s_ready, m_valid, m_data, m_dest, m_id, m_last
  );

  modport slave (
    output s_valid, s_data, s_dest, s_id, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_dest, m_id, m_last
  );

endinterface

// File: rtl/axis_wrr_packet_arbiter_picker.sv
// Combinational rotating-priority search.
//  req   : request vector
//  ptr   : index that has highest priority this cycle
//  found : at least one request is set
//  idx   : first set request scanning ptr, ptr+1, ... modulo N
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int SB = sel_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SB-1:0] ptr,
  output logic          found,
  output logic [SB-1:0] idx
);

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        found = 1'b1;
        idx   = SB'(j);
      end
    end
  end

endmodule

// File: rtl/axis_wrr_packet_arbiter.sv
// Packet-granular weighted round-robin arbiter: one AXI-Stream master shared by
// NSLAVES sources; the granted source may send up to weight[i] packets in a row.
//  aclk, aresetn      : clock, synchronous active-low reset
//  cfg_we/idx/weight  : runtime weight write port (weight 0 behaves as 1)
//  bus                : packed source streams in, shared master stream out
//  grant              : one-hot current owner, zero while arbitrating
module axis_wrr_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NSLAVES      = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int DEST_WIDTH   = 1,
  parameter int ID_WIDTH     = 1,
  parameter int WEIGHT_WIDTH = 4,
  parameter bit HAS_LAST     = 1'b1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         cfg_we,
  input  logic [sel_bits(NSLAVES)-1:0] cfg_idx,
  input  logic [WEIGHT_WIDTH-1:0]      cfg_weight,
  axis_wrr_packet_arbiter_if.master    bus,
  output logic [NSLAVES-1:0]           grant
);

  localparam int SB = sel_bits(NSLAVES);
  localparam logic [WEIGHT_WIDTH-1:0] W_ONE = WEIGHT_WIDTH'(1);

  arb_state_t              state;
  logic [SB-1:0]           ptr, holder, pick_idx, next_ptr, sel;
  logic                    holder_vld, pick_found, regrant, beat, pkt_end;
  logic [WEIGHT_WIDTH-1:0] credit, reload_w;
  logic [WEIGHT_WIDTH-1:0] weight [NSLAVES];
  logic [NSLAVES-1:0]      holder_oh;

  rr_priority_picker #(.N(NSLAVES)) u_picker (
    .req   (bus.s_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The holder keeps the bus without a new search while it has credit and
  // is still requesting; otherwise its leftover credit is simply overwritten.
  assign regrant  = holder_vld && (credit != '0) && bus.s_valid[holder];
  assign reload_w = weight[pick_idx];
  assign next_ptr = (int'(pick_idx) == NSLAVES - 1) ? '0 : pick_idx + SB'(1);
  assign beat     = bus.m_valid && bus.m_ready;
  assign pkt_end  = beat && (bus.s_last[holder] || (HAS_LAST == 1'b0));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      ptr        <= '0;
      holder     <= '0;
      holder_vld <= 1'b0;
      credit     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (regrant) begin
            state <= XFER;
          end else if (pick_found) begin
            state      <= XFER;
            holder     <= pick_idx;
            holder_vld <= 1'b1;
            credit     <= (reload_w == '0) ? W_ONE : reload_w;
            ptr        <= next_ptr;
          end
        end
        XFER: begin
          if (pkt_end) begin
            state <= IDLE;
            if (credit != '0) credit <= credit - W_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writes land at the clock edge, so a reload in the same cycle still sees
  // the previous weight.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NSLAVES; i++) begin
      if (!aresetn) weight[i] <= W_ONE;
      else if (cfg_we && (int'(cfg_idx) == i)) weight[i] <= cfg_weight;
    end
  end

  assign holder_oh = NSLAVES'(onehot(int'(holder), NSLAVES));
  assign grant     = (state == XFER) ? holder_oh : '0;

  always_comb begin
    bus.s_ready = '0;
    bus.m_valid = 1'b0;
    if (state == XFER) begin
      bus.s_ready[holder] = bus.m_ready;
      bus.m_valid         = bus.s_valid[holder];
    end
  end

  // Idle master payload is pinned to source 0 so it does not toggle.
  assign sel        = bus.m_valid ? holder : '0;
  assign bus.m_data = bus.s_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.m_dest = bus.s_dest[int'(sel)*DEST_WIDTH +: DEST_WIDTH];
  assign bus.m_id   = bus.s_id[int'(sel)*ID_WIDTH +: ID_WIDTH];
  assign bus.m_last = bus.s_last[sel];

endmodule

// File: tb/tb_axis_wrr_packet_arbiter.sv
// Self-checking bench: packet-level sources, expected grant order generated
// from the weighted round-robin rule, per-beat scoreboard on the master side.
module tb_axis_wrr_packet_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int WW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic [WW-1:0] cfg_weight = '0;
  logic [NS-1:0] grant;

  axis_wrr_packet_arbiter_if #(.NSLAVES(NS), .DATA_WIDTH(DW), .DEST_WIDTH(1), .ID_WIDTH(1)) bus ();

  axis_wrr_packet_arbiter #(
    .NSLAVES(NS), .DATA_WIDTH(DW), .DEST_WIDTH(1), .ID_WIDTH(1),
    .WEIGHT_WIDTH(WW), .HAS_LAST(1'b1)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
    .bus        (bus),
    .grant      (grant)
  );

  always #5 aclk = ~aclk;

  int n_assert = 0;
  int n_fail   = 0;
  int cycle    = 0;

  int lens [NS][64];
  int p [NS], b [NS], avail [NS];
  int sb_p [NS], sb_b [NS];
  int wmodel [NS];
  int exp_q [$];
  int pkts_done, last_beat_cyc;
  int mready_mode, gap_pct, fg_src, fg_beat, fg_left;
  bit tput_en;
  logic [NS-1:0] hs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_tb();
    for (int s = 0; s < NS; s++) begin
      p[s] = 0; b[s] = 0; sb_p[s] = 0; sb_b[s] = 0; avail[s] = 0; wmodel[s] = 1;
    end
    exp_q.delete();
    pkts_done = 0; last_beat_cyc = -1; tput_en = 1'b0;
    mready_mode = 0; gap_pct = 0; fg_src = -1; fg_beat = 0; fg_left = 0;
  endtask

  task automatic set_lens(input int fixed);
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 64; k++)
        lens[s][k] = (fixed > 0) ? fixed : int'($urandom_range(4, 1));
  endtask

  // Expected grant order when every source always has a packet waiting.
  task automatic build_order(input int start, input int n);
    int s, cnt, reps;
    s = start; cnt = 0;
    while (cnt < n) begin
      reps = (wmodel[s] == 0) ? 1 : wmodel[s];
      for (int r = 0; r < reps && cnt < n; r++) begin
        exp_q.push_back(s);
        cnt++;
      end
      s = (s + 1) % NS;
    end
  endtask

  task automatic drive_sources();
    logic gap;
    for (int s = 0; s < NS; s++) begin
      gap = 1'b0;
      if (b[s] > 0 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct) gap = 1'b1;
      if (s == fg_src && b[s] == fg_beat && fg_left > 0) begin
        gap = 1'b1;
        fg_left--;
      end
      bus.s_valid[s] = (avail[s] != 0 || b[s] > 0) && !gap;
      bus.s_data[s*DW +: DW] = {32'(s), 16'(p[s]), 16'(b[s])};
      bus.s_last[s] = (b[s] + 1 == lens[s][p[s] % 64]);
      bus.s_id[s]   = 1'(s & 1);
      bus.s_dest[s] = 1'((s >> 1) & 1);
    end
    case (mready_mode)
      1:       bus.m_ready = ($urandom_range(3) != 0);
      2:       bus.m_ready = (cycle % 2 == 0);
      default: bus.m_ready = 1'b1;
    endcase
  endtask

  task automatic check_cycle(input bit rst_chk);
    logic [NS-1:0] exp_oh;
    int src;
    bit is_last;
    exp_oh = (exp_q.size() > 0) ? NS'(1 << exp_q[0]) : '0;
    if (rst_chk) begin
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_s_ready", 64'(bus.s_ready), 64'(0));
      check("rst_m_valid", 64'(bus.m_valid), 64'(0));
    end
    check("grant_owner", 64'(grant & ~exp_oh), 64'(0));
    check("s_ready_other", 64'(bus.s_ready & ~(bus.m_ready ? exp_oh : '0)), 64'(0));
    if (exp_q.size() > 0 && sb_b[exp_q[0]] > 0) check("grant_held", 64'(grant), 64'(exp_oh));
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_grant", 64'(grant), 64'(0));
      end else begin
        src = exp_q[0];
        is_last = (sb_b[src] + 1 == lens[src][sb_p[src] % 64]);
        check("beat_data", bus.m_data, {32'(src), 16'(sb_p[src]), 16'(sb_b[src])});
        check("beat_last", 64'(bus.m_last), 64'(is_last));
        check("beat_id", 64'(bus.m_id), 64'(src & 1));
        check("beat_dest", 64'(bus.m_dest), 64'((src >> 1) & 1));
        if (tput_en && last_beat_cyc >= 0) check("tput_gap", 64'(cycle - last_beat_cyc), 64'(2));
        last_beat_cyc = cycle;
        if (is_last) begin
          sb_b[src] = 0;
          sb_p[src]++;
          void'(exp_q.pop_front());
          pkts_done++;
        end else begin
          sb_b[src]++;
        end
      end
    end
  endtask

  task automatic tick(input bit rst_chk);
    drive_sources();
    #1;
    if (aresetn) check_cycle(rst_chk);
    hs = bus.s_valid & bus.s_ready;
    @(posedge aclk);
    for (int s = 0; s < NS; s++) begin
      if (hs[s] === 1'b1) begin
        if (b[s] + 1 == lens[s][p[s] % 64]) begin
          b[s] = 0;
          p[s]++;
          if (avail[s] > 0) avail[s]--;
        end else begin
          b[s]++;
        end
      end
    end
    cycle++;
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick(1'b0);
    aresetn = 1'b1;
    reset_tb();
  endtask

  task automatic cfg_write(input int idx, input int w);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_weight = WW'(w);
    tick(1'b0);
    cfg_we = 1'b0;
    wmodel[idx] = w;
  endtask

  task automatic run(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (pkts_done < n && k < budget) begin
      tick(1'b0);
      k++;
    end
    check(tag, 64'(pkts_done), 64'(n));
  endtask

  initial begin
    int k;
    bus.s_valid = '0; bus.s_data = '0; bus.s_dest = '0; bus.s_id = '0;
    bus.s_last = '0; bus.m_ready = 1'b0;
    reset_tb();
    set_lens(1);
    @(negedge aclk);

    // Power-on reset, then the idle state right after it.
    aresetn = 1'b0;
    tick(1'b0);
    tick(1'b0);
    aresetn = 1'b1;
    reset_tb();
    tick(1'b1);

    // weight[0]=3: 0,0,0,1,2,3,... ; src1's third packet is 4 beats long.
    cfg_write(0, 3);
    set_lens(1);
    lens[1][2] = 4;
    for (int s = 0; s < NS; s++) avail[s] = -1;
    build_order(0, 20);
    k = 0;
    while (!(sb_p[1] == 2 && sb_b[1] == 2) && k < 400) begin
      tick(1'b0);
      k++;
    end
    check("t3_mid_pkt_reached", 64'(sb_p[1] * 16 + sb_b[1]), 64'(2 * 16 + 2));
    check("t3_pkts_before_mid", 64'(pkts_done), 64'(15));

    // Reset with src1 at beat 2 of 4; weights must return to 1.
    aresetn = 1'b0;
    tick(1'b0);
    aresetn = 1'b1;
    reset_tb();
    set_lens(1);
    for (int s = 0; s < NS; s++) avail[s] = -1;
    build_order(0, 16);
    tput_en = 1'b1;
    tick(1'b1);
    run("t2_equal_weights_pkts", 16, 200);

    // src2 4-beat packet, m_ready toggling, gap at beat 2; others join later.
    do_reset();
    set_lens(1);
    lens[2][0] = 4;
    avail[2] = -1;
    mready_mode = 2;
    fg_src = 2; fg_beat = 2; fg_left = 2;
    exp_q.push_back(2);
    k = 0;
    while (grant !== 4'b0100 && k < 20) begin
      tick(1'b0);
      k++;
    end
    check("t4_src2_granted", 64'(grant), 64'(4'b0100));
    avail[0] = -1; avail[1] = -1; avail[3] = -1;
    build_order(3, 7);
    run("t4_pkts", 8, 300);

    // weight[1]=3 but src1 offers a single packet; src3 takes over.
    do_reset();
    set_lens(1);
    cfg_write(1, 3);
    avail[1] = 1;
    avail[3] = -1;
    exp_q = {1, 3, 3, 3, 3, 3};
    run("t5_pkts", 6, 100);

    // weight[0] 2 -> 0 while src0 owns the bus.
    do_reset();
    set_lens(2);
    cfg_write(0, 2);
    for (int s = 0; s < NS; s++) avail[s] = -1;
    exp_q = {0, 0};
    wmodel[0] = 0;
    build_order(1, 8);
    k = 0;
    while (grant !== 4'b0001 && k < 20) begin
      tick(1'b0);
      k++;
    end
    check("t6_src0_granted", 64'(grant), 64'(4'b0001));
    cfg_write(0, 0);
    run("t6_pkts", 10, 200);

    // Random weights, packet lengths, back-pressure and mid-packet bubbles.
    do_reset();
    set_lens(0);
    for (int s = 0; s < NS; s++) cfg_write(s, int'($urandom_range(3)));
    for (int s = 0; s < NS; s++) avail[s] = -1;
    mready_mode = 1;
    gap_pct = 25;
    build_order(0, 40);
    run("rand_pkts", 40, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
